// File: rtl/seq_det_ctrl_if.sv
// Config channel of the serial pattern detector.
// Host drives the fields; detector answers with cfg_ready.
interface seq_det_ctrl_if #(
  parameter int PW = 8,
  parameter int CW = 8
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [PW-1:0] cfg_pattern;
  logic [3:0]    cfg_len;
  logic          cfg_overlap;
  logic [CW-1:0] cfg_target;

  modport master (
    output cfg_valid,
    output cfg_pattern,
    output cfg_len,
    output cfg_overlap,
    output cfg_target,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_pattern,
    input  cfg_len,
    input  cfg_overlap,
    input  cfg_target,
    output cfg_ready
  );
endinterface

// File: rtl/seq_det_ctrl.sv
// Programmable Mealy serial pattern detector with
// arm/abort sequencing and a match-count stop target.
module seq_det_ctrl #(
  parameter int PW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  seq_det_ctrl_if.slave cfg,
  input  logic          start,
  input  logic          abort,
  input  logic          x_valid,
  input  logic          x,
  output logic          y,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] match_count
);

  localparam int FW = $clog2(PW);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DONE
  } state_t;

  state_t        state, state_n;

  logic [PW-1:0] pat_r;
  logic [3:0]    len_r;
  logic          ovl_r;
  logic [CW-1:0] tgt_r;

  logic [PW-1:0] act_pat;
  logic [3:0]    act_len;
  logic          act_ovl;
  logic [CW-1:0] act_tgt;

  logic [PW-2:0] hist, hist_n;
  logic [FW-1:0] fill, fill_n;
  logic [CW-1:0] cnt, cnt_n;

  logic [PW-1:0] cand;
  logic [PW-1:0] mask;
  logic [3:0]    fill4;
  logic          hit;
  logic          hs;
  logic [CW:0]   cnt_p1;
  logic [CW-1:0] cnt_inc;
  logic          tgt_hit;

  function automatic logic [3:0] clamp_len(
    input logic [3:0] l
  );
    if (l < 4'd2) return 4'd2;
    if (int'(l) > PW) return 4'(PW);
    return l;
  endfunction

  assign cfg.cfg_ready = (state == IDLE);
  assign hs = cfg.cfg_valid & cfg.cfg_ready;

  assign busy        = (state == ARMED);
  assign done        = (state == DONE);
  assign match_count = cnt;

  assign cand  = {hist, x};
  assign fill4 = 4'(fill);

  always_comb begin
    mask = '0;
    for (int i = 0; i < PW; i++)
      mask[i] = (i < int'(act_len));
  end

  // Only the low len bits of the pattern take part.
  assign hit = (state == ARMED) & x_valid
             & (fill4 >= act_len - 4'd1)
             & (((cand ^ act_pat) & mask) == '0);

  assign y = hit & rst;

  assign cnt_p1  = {1'b0, cnt} + 1'b1;
  assign cnt_inc = (&cnt) ? cnt : cnt_p1[CW-1:0];
  assign tgt_hit = (act_tgt != '0)
                 & (cnt_p1 == {1'b0, act_tgt});

  always_comb begin
    state_n = state;
    hist_n  = hist;
    fill_n  = fill;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (start & ~abort) begin
          state_n = ARMED;
          hist_n  = '0;
          fill_n  = '0;
          cnt_n   = '0;
        end
      end
      ARMED: begin
        if (abort) begin
          state_n = IDLE;
        end else if (x_valid) begin
          if (hit & ~act_ovl) begin
            hist_n = '0;
            fill_n = '0;
          end else begin
            hist_n = cand[PW-2:0];
            if (fill != FW'(PW - 1))
              fill_n = fill + 1'b1;
          end
          if (hit) begin
            cnt_n = cnt_inc;
            if (tgt_hit) state_n = DONE;
          end
        end
      end
      DONE: begin
        if (abort) begin
          state_n = IDLE;
        end else if (start) begin
          state_n = ARMED;
          hist_n  = '0;
          fill_n  = '0;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      pat_r   <= PW'(8'b0000_1011);
      len_r   <= 4'd4;
      ovl_r   <= 1'b1;
      tgt_r   <= '0;
      act_pat <= PW'(8'b0000_1011);
      act_len <= 4'd4;
      act_ovl <= 1'b1;
      act_tgt <= '0;
      hist    <= '0;
      fill    <= '0;
      cnt     <= '0;
    end else begin
      state <= state_n;
      hist  <= hist_n;
      fill  <= fill_n;
      cnt   <= cnt_n;
      if (hs) begin
        pat_r <= cfg.cfg_pattern;
        len_r <= clamp_len(cfg.cfg_len);
        ovl_r <= cfg.cfg_overlap;
        tgt_r <= cfg.cfg_target;
      end
      // Active copy lags one cycle, so a same-cycle
      // cfg+start arms on the previous settings.
      act_pat <= pat_r;
      act_len <= len_r;
      act_ovl <= ovl_r;
      act_tgt <= tgt_r;
    end
  end

endmodule
